// File: rtl/m_dmem_resp.sv
// rtl/m_dmem_resp.sv - word data-memory responder with wait states over valid/ready channels
// Optional byte-strobe writes are enabled by defining DMEM_BYTE_STROBE_EN.
module m_dmem_resp #(
    parameter int DEPTH_LOG2  = 6,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        w_clk,
    input  logic        w_rst_n,
    input  logic        w_req_valid,
    output logic        w_req_ready,
    input  logic        w_req_we,
    input  logic [31:0] w_req_addr,
    input  logic [31:0] w_req_wdata,
    input  logic [3:0]  w_req_wstrb,
    output logic        w_rsp_valid,
    input  logic        w_rsp_ready,
    output logic [31:0] w_rsp_rdata,
    output logic        w_rsp_err,
    output logic        w_busy
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);
`ifdef DMEM_BYTE_STROBE_EN
    localparam logic STROBE_EN = 1'b1;
`else
    localparam logic STROBE_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        ready_q, ready_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [31:0] mem_q [DEPTH];

    logic                  accept;
    logic                  enter_resp;
    logic                  cur_we;
    logic [31:0]           cur_addr;
    logic [31:0]           cur_wdata;
    logic [3:0]            cur_wmask;
    logic                  addr_err;
    logic                  do_write;
    logic [DEPTH_LOG2-1:0] idx;

    // With WAIT_CYCLES=0 the access happens on the acceptance edge, so the
    // live request fields are used while still in IDLE.
    always_comb begin
        accept     = (state_q == S_IDLE) && ready_q && w_req_valid;
        cur_we     = (state_q == S_IDLE) ? w_req_we    : we_q;
        cur_addr   = (state_q == S_IDLE) ? w_req_addr  : addr_q;
        cur_wdata  = (state_q == S_IDLE) ? w_req_wdata : wdata_q;
        cur_wmask  = ((state_q == S_IDLE) ? w_req_wstrb : wstrb_q) | {4{~STROBE_EN}};
        addr_err   = (cur_addr[1:0] != 2'b00) || (|cur_addr[31:DEPTH_LOG2+2]);
        idx        = cur_addr[DEPTH_LOG2+1:2];
        enter_resp = (state_d == S_RESP) && (state_q != S_RESP);
        do_write   = enter_resp && cur_we && !addr_err;
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            wstrb_q <= 4'd0;
            ready_q <= 1'b0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    cnt_d   = 4'd0;
                    state_d = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == WAIT_LAST) state_d = S_RESP;
                else                    cnt_d   = cnt_q + 4'd1;
            end
            S_RESP: begin
                if (w_rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        if (accept) begin
            we_d    = w_req_we;
            addr_d  = w_req_addr;
            wdata_d = w_req_wdata;
            wstrb_d = w_req_wstrb;
        end
        ready_d = (state_d == S_IDLE);
        rdata_d = rdata_q;
        err_d   = err_q;
        if (enter_resp) begin
            err_d   = addr_err;
            rdata_d = (addr_err || cur_we) ? 32'd0 : mem_q[idx];
        end else if ((state_q == S_RESP) && (state_d == S_IDLE)) begin
            err_d   = 1'b0;
            rdata_d = 32'd0;
        end
    end

    always_comb begin
        w_req_ready = ready_q;
        w_rsp_valid = (state_q == S_RESP);
        w_rsp_rdata = rdata_q;
        w_rsp_err   = err_q;
        w_busy      = (state_q != S_IDLE);
    end

    always_ff @(posedge w_clk) begin
        if (do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (cur_wmask[i]) mem_q[idx][8*i +: 8] <= cur_wdata[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_m_dmem_resp.sv
// tb/tb_m_dmem_resp.sv - randomized self-checking bench for m_dmem_resp against a word-array model
module tb_m_dmem_resp;
    localparam int W = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic        req_ready, rsp_valid, rsp_err, busy;
    logic [31:0] rsp_rdata;

    logic        req_valid0 = 1'b0, req_we0 = 1'b0, rsp_ready0 = 1'b0;
    logic [31:0] req_addr0 = '0, req_wdata0 = '0;
    logic [3:0]  req_wstrb0 = '0;
    logic        req_ready0, rsp_valid0, rsp_err0, busy0;
    logic [31:0] rsp_rdata0;

    logic [31:0] mem_m  [64];
    logic [31:0] mem0_m [64];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    m_dmem_resp #(.DEPTH_LOG2(6), .WAIT_CYCLES(W)) dut (
        .w_clk(clk), .w_rst_n(rst_n), .w_req_valid(req_valid), .w_req_ready(req_ready),
        .w_req_we(req_we), .w_req_addr(req_addr), .w_req_wdata(req_wdata), .w_req_wstrb(req_wstrb),
        .w_rsp_valid(rsp_valid), .w_rsp_ready(rsp_ready), .w_rsp_rdata(rsp_rdata),
        .w_rsp_err(rsp_err), .w_busy(busy)
    );

    m_dmem_resp #(.DEPTH_LOG2(6), .WAIT_CYCLES(0)) dut0 (
        .w_clk(clk), .w_rst_n(rst_n), .w_req_valid(req_valid0), .w_req_ready(req_ready0),
        .w_req_we(req_we0), .w_req_addr(req_addr0), .w_req_wdata(req_wdata0), .w_req_wstrb(req_wstrb0),
        .w_rsp_valid(rsp_valid0), .w_rsp_ready(rsp_ready0), .w_rsp_rdata(rsp_rdata0),
        .w_rsp_err(rsp_err0), .w_busy(busy0)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp);
        end
    endtask

    function automatic logic m_err(input logic [31:0] a);
        return (a % 4 != 0) || (a >= 32'd256);
    endfunction

    function automatic logic [31:0] m_merge(input logic [31:0] old, input logic [31:0] wd,
                                           input logic [3:0] strb);
        logic [31:0] r;
        r = wd;
`ifdef DMEM_BYTE_STROBE_EN
        r = old;
        for (int i = 0; i < 4; i++) if (strb[i]) r[8*i +: 8] = wd[8*i +: 8];
`endif
        return r;
    endfunction

    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] strb, input int hold);
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          n;
        @(negedge clk);
        check_eq("idle_ready", req_ready, 1);
        check_eq("idle_busy", busy, 0);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_wstrb = strb;
        rsp_ready = (hold == 0);
        @(posedge clk);
        exp_err = m_err(addr);
        exp_rdata = 32'd0;
        if (!exp_err) begin
            if (we) mem_m[addr / 4] = m_merge(mem_m[addr / 4], wd, strb);
            else    exp_rdata = mem_m[addr / 4];
        end
        @(negedge clk);
        req_valid = 1'($urandom); req_we = 1'($urandom); req_addr = $urandom;
        req_wdata = $urandom; req_wstrb = 4'($urandom);
        n = 1;
        while (!rsp_valid && n < 20) begin
            check_eq("wait_ready", req_ready, 0);
            check_eq("wait_busy", busy, 1);
            @(negedge clk);
            n++;
        end
        req_valid = 1'b0;
        check_eq("rsp_latency", n, W + 1);
        check_eq("rsp_rdata", rsp_rdata, exp_rdata);
        check_eq("rsp_err", rsp_err, exp_err);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq("hold_valid", rsp_valid, 1);
            check_eq("hold_rdata", rsp_rdata, exp_rdata);
            check_eq("hold_err", rsp_err, exp_err);
            check_eq("hold_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check_eq("done_valid", rsp_valid, 0);
        check_eq("done_rdata", rsp_rdata, 0);
        check_eq("done_err", rsp_err, 0);
        check_eq("done_busy", busy, 0);
        check_eq("done_ready", req_ready, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, d;
        logic        q_we [12];
        logic [31:0] q_addr [12];
        logic [31:0] q_data [12];
        logic [31:0] e_rdata;
        logic        e_err;

        #12;
        check_eq("rst_ready", req_ready, 0);
        check_eq("rst_valid", rsp_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_rdata", rsp_rdata, 0);
        check_eq("rst_err", rsp_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check_eq("release_ready_low", req_ready, 0);
        @(negedge clk);
        check_eq("release_ready_high", req_ready, 1);

        for (int i = 0; i < 64; i++) txn(1'b1, 32'(i * 4), $urandom, 4'hF, 0);

        // reset in the middle of a store's wait states discards the store
        txn(1'b1, 32'h10, 32'h0, 4'hF, 0);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h12345678; req_wstrb = 4'hF;
        @(negedge clk);
        req_valid = 1'b0;
        check_eq("midwait_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_valid", rsp_valid, 0);
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_ready", req_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("midrst_ready_back", req_ready, 1);
        check_eq("midrst_valid_back", rsp_valid, 0);
        txn(1'b0, 32'h10, 0, 0, 0);

        txn(1'b1, 32'h20, 32'hDEADBEEF, 4'hF, 0);
        txn(1'b0, 32'h20, 0, 0, 0);
        txn(1'b0, 32'h22, 0, 0, 0);
        txn(1'b1, 32'h100, 32'hCAFEF00D, 4'hF, 0);
        txn(1'b0, 32'h0, 0, 0, 0);
        txn(1'b0, 32'h20, 0, 0, 0);
        txn(1'b0, 32'h20, 0, 0, 5);
        txn(1'b1, 32'h30, 32'h11223344, 4'hF, 0);
        txn(1'b1, 32'h30, 32'hAABBCCDD, 4'b0101, 0);
        txn(1'b0, 32'h30, 0, 0, 0);
        txn(1'b1, 32'h34, 32'h55667788, 4'b0000, 1);
        txn(1'b0, 32'h34, 0, 0, 0);

        for (int i = 0; i < 60; i++) begin
            a = ($urandom_range(0, 9) < 8) ? 32'($urandom_range(0, 63) * 4) : $urandom;
            if ($urandom_range(0, 3) == 0) a = a | 32'h1;
            txn(1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 3));
        end

        // zero wait states, valid held high: one request every two cycles
        for (int i = 0; i < 12; i++) begin
            q_we[i]   = (i < 4);
            q_addr[i] = (i < 4) ? 32'(i * 4) : 32'($urandom_range(0, 3) * 4);
            q_data[i] = $urandom;
        end
        q_addr[11] = 32'h6;
        e_rdata = 0;
        e_err = 0;
        @(negedge clk);
        rsp_ready0 = 1'b1;
        for (int k = 0; k < 24; k++) begin
            if (k % 2 == 0) begin
                check_eq("z_ready", req_ready0, 1);
                check_eq("z_valid_low", rsp_valid0, 0);
                req_valid0 = 1'b1; req_we0 = q_we[k/2]; req_addr0 = q_addr[k/2];
                req_wdata0 = q_data[k/2]; req_wstrb0 = 4'hF;
                e_err = m_err(q_addr[k/2]);
                e_rdata = 0;
                if (!e_err) begin
                    if (q_we[k/2]) mem0_m[q_addr[k/2] / 4] = q_data[k/2];
                    else           e_rdata = mem0_m[q_addr[k/2] / 4];
                end
            end else begin
                check_eq("z_ready_low", req_ready0, 0);
                check_eq("z_valid", rsp_valid0, 1);
                check_eq("z_rdata", rsp_rdata0, e_rdata);
                check_eq("z_err", rsp_err0, e_err);
            end
            @(negedge clk);
        end
        req_valid0 = 1'b0;
        d = 32'(busy0);
        @(negedge clk);
        check_eq("z_final_busy", busy0, 0);
        check_eq("z_final_valid", rsp_valid0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
